subbyte_scheduler: RTL and testbench

Sequenced, shared SubBytes engine for the AES-128 core. It time-multiplexes a small bank of S-box lanes between two requesters. The first is the round datapath, which sends a 128-bit state, forward or inverse. The second is key expansion, which sends a 32-bit SubWord request. Both requesters use valid/ready handshakes, and the block contains the arbitration, the beat counter and the result assembly.

---
 rtl/subbyte_scheduler.sv | 144 ++++++++++++++
 tb/tb_subbyte_scheduler.sv | 127 ++++++++++++
 2 files changed

// File: rtl/subbyte_scheduler.sv
// subbyte_scheduler: shared AES SubBytes lanes arbitrated between round-state and key-expansion requests (SUBBYTE_INV_EN adds inverse lanes)
module subbyte_scheduler #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic         st_inv,
    input  logic [127:0] st_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         ks_valid,
    output logic         ks_ready,
    input  logic [31:0]  ks_word,
    output logic         ks_out_valid,
    output logic [31:0]  ks_out_word
);
    localparam int BEATS = 16 / LANES;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, s;
        p = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            p = gf_mul(p, s);
        end
        return p;
    endfunction
    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction
`ifdef SUBBYTE_INV_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction
`endif
    state_t        r_state;
    logic          r_run;
    logic          r_rr_ks;
    logic [3:0]    r_beat;
    logic [127:0]  r_data;
    logic [127:0]  r_res;
    logic          r_ks_out_valid;
    logic [31:0]   r_ks_out_word;
    logic [7:0]    w_busy_in [LANES];
    logic [7:0]    w_lane_in [LANES];
    logic [7:0]    w_lane_out [LANES];
    logic          w_busy;
    logic          w_st_acc;
    logic          w_ks_acc;
    assign w_busy       = (r_state == BUSY);
    assign st_ready     = r_run & (r_state == IDLE) & (~ks_valid | r_rr_ks);
    assign ks_ready     = r_run & ((r_state == DONE) | ((r_state == IDLE) & ~(st_valid & r_rr_ks)));
    assign w_st_acc     = st_valid & st_ready;
    assign w_ks_acc     = ks_valid & ks_ready;
    assign st_out_valid = (r_state == DONE);
    assign st_out_data  = r_res;
    assign ks_out_valid = r_ks_out_valid;
    assign ks_out_word  = r_ks_out_word;
`ifdef SUBBYTE_INV_EN
    logic r_inv;
    logic w_inv_sel;
    assign w_inv_sel = w_busy & r_inv;
`else
    logic w_unused_st_inv;
    assign w_unused_st_inv = st_inv;
`endif
    // Pick the captured-state bytes belonging to the current beat
    always_comb begin
        for (int l = 0; l < LANES; l++) w_busy_in[l] = 8'h00;
        for (int b = 0; b < 16; b++)
            if (4'(b / LANES) == r_beat) w_busy_in[b % LANES] = r_data[127 - 8*b -: 8];
    end
    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            if (l < 4) begin : g_ks
                assign w_lane_in[l] = w_busy ? w_busy_in[l] : ks_word[31 - 8*l -: 8];
            end else begin : g_st
                assign w_lane_in[l] = w_busy ? w_busy_in[l] : 8'h00;
            end
`ifdef SUBBYTE_INV_EN
            assign w_lane_out[l] = w_inv_sel ? inv_sbox(w_lane_in[l]) : sbox(w_lane_in[l]);
`else
            assign w_lane_out[l] = sbox(w_lane_in[l]);
`endif
        end
    endgenerate
    // Arbitration, beat sequencing and result assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_run          <= 1'b0;
            r_rr_ks        <= 1'b1;
            r_beat         <= 4'd0;
            r_data         <= '0;
            r_res          <= '0;
            r_ks_out_valid <= 1'b0;
            r_ks_out_word  <= '0;
`ifdef SUBBYTE_INV_EN
            r_inv          <= 1'b0;
`endif
        end else begin
            r_run          <= 1'b1;
            r_ks_out_valid <= w_ks_acc;
            if (w_ks_acc) r_ks_out_word <= {w_lane_out[0], w_lane_out[1], w_lane_out[2], w_lane_out[3]};
            if (w_ks_acc && r_state == IDLE) r_rr_ks <= 1'b1;
            if (w_st_acc) begin
                r_data  <= st_data;
                r_beat  <= 4'd0;
                r_state <= BUSY;
                r_rr_ks <= 1'b0;
`ifdef SUBBYTE_INV_EN
                r_inv   <= st_inv;
`endif
            end
            if (w_busy) begin
                for (int b = 0; b < 16; b++)
                    if (4'(b / LANES) == r_beat) r_res[127 - 8*b -: 8] <= w_lane_out[b % LANES];
                r_beat <= r_beat + 4'd1;
                if (r_beat == 4'(BEATS - 1)) r_state <= DONE;
            end
            if (r_state == DONE && st_out_ready) r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_subbyte_scheduler.sv
// tb_subbyte_scheduler: directed checks of arbitration, latency, backpressure and reset for subbyte_scheduler
module tb_subbyte_scheduler;
    localparam logic [127:0] FWD_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] FWD_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;
`ifdef SUBBYTE_INV_EN
    localparam logic [127:0] INV_EXP = FWD_IN;
`else
    localparam logic [127:0] INV_EXP = 128'hfb74a9f201ed70d1bdd0e194f451f864;
`endif
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st_valid, st_ready, st_inv, st_out_valid, st_out_ready;
    logic [127:0] st_data, st_out_data;
    logic         ks_valid, ks_ready, ks_out_valid;
    logic [31:0]  ks_word, ks_out_word;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    subbyte_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_inv(st_inv), .st_data(st_data),
        .st_out_valid(st_out_valid), .st_out_ready(st_out_ready), .st_out_data(st_out_data),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_word(ks_word),
        .ks_out_valid(ks_out_valid), .ks_out_word(ks_out_word)
    );
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic check_idle_outputs(input string tag);
        check({tag, "_st_ready"}, 128'(st_ready), 128'd0);
        check({tag, "_ks_ready"}, 128'(ks_ready), 128'd0);
        check({tag, "_st_out_valid"}, 128'(st_out_valid), 128'd0);
        check({tag, "_st_out_data"}, st_out_data, 128'd0);
        check({tag, "_ks_out_valid"}, 128'(ks_out_valid), 128'd0);
        check({tag, "_ks_out_word"}, 128'(ks_out_word), 128'd0);
    endtask
    initial begin
        st_valid = 1'b1; ks_valid = 1'b1; st_data = FWD_IN; st_inv = 1'b0;
        st_out_ready = 1'b0; ks_word = 32'hcf4f3c09;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        #1;
        check("prerun_st_ready", 128'(st_ready), 128'd0);
        check("prerun_ks_ready", 128'(ks_ready), 128'd0);
        @(negedge clk);
        check("cont1_st_ready", 128'(st_ready), 128'd1);
        check("cont1_ks_ready", 128'(ks_ready), 128'd0);
        @(posedge clk); #1;
        st_valid = 1'b0; st_data = '1;
        @(negedge clk);
        check("busy_st_ready", 128'(st_ready), 128'd0);
        check("busy_ks_ready", 128'(ks_ready), 128'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lat3_valid", 128'(st_out_valid), 128'd0);
        @(negedge clk);
        check("lat4_valid", 128'(st_out_valid), 128'd1);
        check("fwd_data", st_out_data, FWD_OUT);
        check("done_ks_ready", 128'(ks_ready), 128'd1);
        @(posedge clk); #1;
        ks_valid = 1'b0; st_valid = 1'b1;
        @(negedge clk);
        check("ks_done_valid", 128'(ks_out_valid), 128'd1);
        check("ks_done_word", 128'(ks_out_word), 128'(32'h8a84eb01));
        check("ks_done_hold", st_out_data, FWD_OUT);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) check("ks_pulse_end", 128'(ks_out_valid), 128'd0);
            check("bp_valid", 128'(st_out_valid), 128'd1);
            check("bp_data", st_out_data, FWD_OUT);
            check("bp_st_ready", 128'(st_ready), 128'd0);
        end
        @(posedge clk); #1;
        st_out_ready = 1'b1; ks_valid = 1'b1; ks_word = 32'h09cf4f3c;
        @(negedge clk);
        check("hs_ks_ready", 128'(ks_ready), 128'd1);
        check("hs_st_ready", 128'(st_ready), 128'd0);
        check("hs_valid", 128'(st_out_valid), 128'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("hs_done", 128'(st_out_valid), 128'd0);
        check("hs_ks_valid", 128'(ks_out_valid), 128'd1);
        check("hs_ks_word", 128'(ks_out_word), 128'(32'h018a84eb));
        check("cont2_ks_ready", 128'(ks_ready), 128'd1);
        check("cont2_st_ready", 128'(st_ready), 128'd0);
        @(posedge clk); #1;
        ks_valid = 1'b0; st_data = FWD_OUT; st_inv = 1'b1;
        @(negedge clk);
        check("inv_st_ready", 128'(st_ready), 128'd1);
        @(posedge clk); #1;
        st_valid = 1'b0; st_inv = 1'b0; st_data = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("inv_valid", 128'(st_out_valid), 128'd1);
        check("inv_data", st_out_data, INV_EXP);
        @(negedge clk);
        check("inv_hs_done", 128'(st_out_valid), 128'd0);
        st_valid = 1'b1; st_data = FWD_IN;
        @(posedge clk); #1;
        st_valid = 1'b0; ks_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ks_ready", 128'(ks_ready), 128'd0);
        @(negedge clk);
        check("rel_ks_ready_run", 128'(ks_ready), 128'd1);
        ks_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_out", 128'(st_out_valid), 128'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
